// File: rtl/spi_reg_sequencer.sv
// Register-transaction sequencer feeding an SPI main: command FIFO, one-frame-at-a-time FSM, read response port.
// Optional auto-poll reads are compiled in with the SPI_SEQ_POLL_EN macro.
module spi_reg_sequencer #(
    parameter int ADDR_WIDTH      = 6,
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int START_TIMEOUT   = 16,
    parameter int POLL_PERIOD     = 1000,
    parameter logic [ADDR_WIDTH-1:0] POLL_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  spi_en,
    output logic                  spi_mode,
    output logic [ADDR_WIDTH-1:0] spi_addr,
    output logic [DATA_WIDTH-1:0] spi_wdata,
    output logic                  spi_write_valid,
    input  logic                  spi_cs,
    input  logic [DATA_WIDTH-1:0] spi_read_data,
    input  logic                  spi_read_valid
);
    localparam int IDX_W   = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = IDX_W + 1;
    localparam int ENT_W   = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_MAX = (START_TIMEOUT > COOLDOWN_CYCLES) ? START_TIMEOUT : COOLDOWN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FRAME, S_COOL} state_t;

    logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic                  fifo_empty, fifo_full, push, pop;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  spi_en_reg, spi_en_next;
    logic                  spi_mode_reg, spi_mode_next;
    logic [ADDR_WIDTH-1:0] spi_addr_reg, spi_addr_next;
    logic [DATA_WIDTH-1:0] spi_wdata_reg, spi_wdata_next;
    logic                  spi_wv_reg, spi_wv_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [ADDR_WIDTH-1:0] rsp_addr_reg, rsp_addr_next;
    logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
    logic                  err_reg, err_next;
    logic                  poll_due, poll_take;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) &&
                        (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]);
    assign push       = cmd_valid && !fifo_full;
    assign {head_write, head_addr, head_wdata} = fifo_mem[rd_ptr_reg[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg[IDX_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

`ifdef SPI_SEQ_POLL_EN
    localparam int POLL_W = $clog2(POLL_PERIOD + 1);
    logic [POLL_W-1:0] poll_cnt_reg;
    logic              poll_due_reg;

    // Once due, the counter parks until the poll is actually injected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt_reg <= '0;
            poll_due_reg <= 1'b0;
        end else if (poll_take) begin
            poll_cnt_reg <= '0;
            poll_due_reg <= 1'b0;
        end else if (!poll_due_reg) begin
            if (poll_cnt_reg == POLL_W'(POLL_PERIOD - 1))
                poll_due_reg <= 1'b1;
            else
                poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
        end
    end
    assign poll_due = poll_due_reg;
`else
    logic unused_poll;
    assign poll_due    = 1'b0;
    assign unused_poll = ^{poll_take, POLL_PERIOD[0]};
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        spi_en_next    = spi_en_reg;
        spi_mode_next  = spi_mode_reg;
        spi_addr_next  = spi_addr_reg;
        spi_wdata_next = spi_wdata_reg;
        spi_wv_next    = spi_wv_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_addr_next  = rsp_addr_reg;
        rsp_data_next  = rsp_data_reg;
        err_next       = err_reg;
        pop            = 1'b0;
        poll_take      = 1'b0;

        if (rsp_valid_reg && rsp_ready)
            rsp_valid_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // Host commands take priority over a due poll; nothing issues while a result is held.
                if (!rsp_valid_reg) begin
                    if (!fifo_empty) begin
                        pop            = 1'b1;
                        spi_mode_next  = head_write;
                        spi_addr_next  = head_addr;
                        spi_wdata_next = head_wdata;
                        spi_en_next    = 1'b1;
                        spi_wv_next    = head_write;
                        cnt_next       = '0;
                        state_next     = S_ISSUE;
                    end else if (poll_due) begin
                        poll_take     = 1'b1;
                        spi_mode_next = 1'b0;
                        spi_addr_next = POLL_ADDR;
                        spi_en_next   = 1'b1;
                        spi_wv_next   = 1'b0;
                        cnt_next      = '0;
                        state_next    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!spi_cs) begin
                    spi_en_next = 1'b0;
                    spi_wv_next = 1'b0;
                    state_next  = S_FRAME;
                end else if (cnt_reg == CNT_W'(START_TIMEOUT - 1)) begin
                    err_next    = 1'b1;
                    spi_en_next = 1'b0;
                    spi_wv_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = S_COOL;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_FRAME: begin
                if (spi_cs) begin
                    if (!spi_mode_reg) begin
                        // A well-behaved main always flags read_valid here; zero data guards against one that does not.
                        rsp_valid_next = 1'b1;
                        rsp_addr_next  = spi_addr_reg;
                        rsp_data_next  = spi_read_valid ? spi_read_data : '0;
                    end
                    cnt_next   = '0;
                    state_next = S_COOL;
                end
            end
            S_COOL: begin
                if (cnt_reg == CNT_W'(COOLDOWN_CYCLES - 1))
                    state_next = S_IDLE;
                else
                    cnt_next = cnt_reg + CNT_W'(1);
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            spi_en_reg    <= 1'b0;
            spi_mode_reg  <= 1'b0;
            spi_addr_reg  <= '0;
            spi_wdata_reg <= '0;
            spi_wv_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_addr_reg  <= '0;
            rsp_data_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            spi_en_reg    <= spi_en_next;
            spi_mode_reg  <= spi_mode_next;
            spi_addr_reg  <= spi_addr_next;
            spi_wdata_reg <= spi_wdata_next;
            spi_wv_reg    <= spi_wv_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_addr_reg  <= rsp_addr_next;
            rsp_data_reg  <= rsp_data_next;
            err_reg       <= err_next;
        end
    end

    assign cmd_ready       = !fifo_full;
    assign busy            = !fifo_empty || (state_reg != S_IDLE);
    assign err_timeout     = err_reg;
    assign spi_en          = spi_en_reg;
    assign spi_mode        = spi_mode_reg;
    assign spi_addr        = spi_addr_reg;
    assign spi_wdata       = spi_wdata_reg;
    assign spi_write_valid = spi_wv_reg;
    assign rsp_valid       = rsp_valid_reg;
    assign rsp_addr        = rsp_addr_reg;
    assign rsp_data        = rsp_data_reg;
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Randomized scoreboard bench for spi_reg_sequencer with a behavioural SPI main and register file.
module tb_spi_reg_sequencer;
    localparam int AW   = 6;
    localparam int DW   = 8;
    localparam int COOL = 8;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b1;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          busy, err_timeout;
    logic          spi_en, spi_mode, spi_write_valid;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_wdata;
    logic          spi_cs = 1'b1;
    logic [DW-1:0] spi_read_data = '0;
    logic          spi_read_valid = 1'b0;

    spi_reg_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .busy(busy), .err_timeout(err_timeout),
        .spi_en(spi_en), .spi_mode(spi_mode), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_write_valid(spi_write_valid), .spi_cs(spi_cs),
        .spi_read_data(spi_read_data), .spi_read_valid(spi_read_valid)
    );

    always #5 clk = ~clk;

    typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} rsp_t;
    typedef struct {logic w; logic [AW-1:0] addr; logic [DW-1:0] data;} frm_t;

    rsp_t          exp_q[$];
    frm_t          frame_q[$];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] slave_mem [64];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_rise = -1;
    int            ready_mode = 1;
    bit            disconnected = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: register file semantics, one response per read reaching a live SPI main.
    function automatic void model_accept(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rsp_t r;
        frm_t f;
        f.w = w; f.addr = a; f.data = d;
        frame_q.push_back(f);
        if (w) begin
            ref_mem[a] = d;
        end else if (!disconnected) begin
            r.addr = a; r.data = ref_mem[a];
            exp_q.push_back(r);
        end
    endfunction

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready) begin
            model_accept(w, a, d);
            $display("cmd  %s addr=%02h data=%02h", w ? "WR" : "RD", a, d);
        end else begin
            check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || rsp_valid || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, {busy, rsp_valid}, 0);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp"}, {rsp_valid, rsp_addr, rsp_data}, 0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err_timeout), 32'd0);
        check({tag, "_spi_ctl"}, {spi_en, spi_mode, spi_write_valid}, 0);
        check({tag, "_spi_data"}, {spi_addr, spi_wdata}, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: rsp_ready = 1'b0;
                1: rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Response monitor: pops the scoreboard on every handshake, and checks held responses stay put.
    logic          prev_held = 1'b0;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    always @(negedge clk) begin
        rsp_t r;
        if (rst) begin
            prev_held = 1'b0;
        end else begin
            if (prev_held)
                check("rsp_hold", {rsp_valid, rsp_addr, rsp_data}, {1'b1, h_addr, h_data});
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    $display("rsp  addr=%02h data=%02h expect %02h/%02h", rsp_addr, rsp_data, r.addr, r.data);
                    check("rsp_addr", 32'(rsp_addr), 32'(r.addr));
                    check("rsp_data", 32'(rsp_data), 32'(r.data));
                end
            end
            prev_held = rsp_valid && !rsp_ready;
            h_addr = rsp_addr;
            h_data = rsp_data;
        end
    end

    // Behavioural SPI main: cs falls two cycles after en, frame of random length, read data on cs rise.
    initial begin
        frm_t          f;
        logic          cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        int            n;
        forever begin
            @(negedge clk);
            if (!rst && spi_en) begin
                cw = spi_mode; ca = spi_addr; cd = spi_wdata;
                if (frame_q.size() == 0) begin
                    check("unexpected_frame", 32'(spi_en), 32'd0);
                end else begin
                    f = frame_q.pop_front();
                    check("frame_mode", {spi_mode, spi_write_valid}, {f.w, f.w});
                    check("frame_addr", 32'(spi_addr), 32'(f.addr));
                    if (f.w)
                        check("frame_wdata", 32'(spi_wdata), 32'(f.data));
                end
                if (last_rise >= 0) begin
                    checks++;
                    if (cyc - last_rise < COOL + 2) begin
                        errors++;
                        $display("FAIL cooldown_gap: got %0d cycles, expected >= %0d", cyc - last_rise, COOL + 2);
                    end
                end
                if (disconnected) begin
                    n = 0;
                    while (spi_en && n < 100) begin
                        n++;
                        @(negedge clk);
                    end
                    check("timeout_en_cycles", n, TMO);
                    last_rise = -1;
                end else begin
                    @(negedge clk);
                    check("en_second_cycle", 32'(spi_en), 32'd1);
                    spi_cs = 1'b0;
                    if (cw)
                        slave_mem[ca] = cd;
                    @(negedge clk);
                    check("en_dropped", 32'(spi_en), 32'd0);
                    repeat ($urandom_range(1, 5)) @(negedge clk);
                    spi_read_data = cw ? 8'h00 : slave_mem[ca];
                    spi_read_valid = 1'b1;
                    spi_cs = 1'b1;
                    last_rise = cyc;
                    @(negedge clk);
                    spi_read_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]   = 8'(i * 37 + 11);
            slave_mem[i] = 8'(i * 37 + 11);
        end
        ref_mem[5] = 8'h5A;
        slave_mem[5] = 8'h5A;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single write: latency to spi_en, no response, busy clears after cooldown.
        send(1'b1, 6'h2A, 8'hC3);
        check("busy_after_push", 32'(busy), 32'd1);
        check("en_not_yet", 32'(spi_en), 32'd0);
        @(negedge clk);
        check("en_latency", {spi_en, spi_mode, spi_write_valid, spi_addr, spi_wdata}, {3'b111, 6'h2A, 8'hC3});
        wait_idle("write_idle");
        check("write_landed", 32'(slave_mem[6'h2A]), 32'hC3);

        // Read held under backpressure, then the FIFO fills behind it.
        ready_mode = 0;
        send(1'b0, 6'h05, 8'h00);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("read_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (10) @(negedge clk);
        send(1'b1, 6'h10, 8'h77);
        send(1'b0, 6'h10, 8'h00);
        send(1'b0, 6'h05, 8'h00);
        send(1'b1, 6'h11, 8'h99);
        check("fifo_full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h3F; cmd_wdata = 8'hEE;
        repeat (3) begin
            check("fifth_refused", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        ready_mode = 1;
        wait_idle("fifo_drain");

        // Back-to-back reads with the consumer always ready.
        send(1'b0, 6'h01, 8'h00);
        send(1'b0, 6'h02, 8'h00);
        send(1'b0, 6'h03, 8'h00);
        wait_idle("b2b_idle");

        // SPI main absent: timeout, no response, following command still runs.
        disconnected = 1'b1;
        send(1'b0, 6'h07, 8'h00);
        n = 0;
        while (!err_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("err_timeout_set", 32'(err_timeout), 32'd1);
        wait_idle("timeout_idle");
        disconnected = 1'b0;
        send(1'b0, 6'h08, 8'h00);
        wait_idle("after_timeout_idle");
        check("err_sticky", 32'(err_timeout), 32'd1);

        // Randomized traffic over a small address window to exercise read-after-write.
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            send(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("random_idle");

        // Reset in the middle of a read frame with more reads queued.
        ready_mode = 1;
        send(1'b0, 6'h03, 8'h00);
        send(1'b0, 6'h04, 8'h00);
        send(1'b0, 6'h05, 8'h00);
        n = 0;
        while (spi_cs && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("frame_started", 32'(spi_cs), 32'd0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        frame_q.delete();
        #1;
        check_reset_values("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_busy", {busy, spi_en}, 0);
        send(1'b0, 6'h2A, 8'h00);
        wait_idle("final_idle");
        check("frames_consumed", frame_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
